alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised, handshaked execute unit for the RISC-V core. It extends the single-cycle integer ALU with unsigned compare, shifts, and iterative multiply and divide. Single-cycle ops return a registered result one cycle after acceptance. Multiply and divide run a WIDTH-iteration shift/add or shift/subtract sequence. It sits between decode/operand fetch and writeback.

## Interface
- WIDTH, 32: operand and result width; must be ≥ 8 and a power of two.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- op  in  4  operation code (see Operation).
- a, b  in  WIDTH  operands.
- out_valid  out  1  result, flags valid.
- out_ready  in  1  consumer takes result this cycle.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow; add/sub only, else 0.
- illegal  out  1  op not supported; result forced to 0.

## Operation
- Op codes:
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 slt (signed)
  - 0110 sltu
  - 0111 sll
  - 1000 srl
  - 1001 sra
  - 1010 mul (low WIDTH bits)
  - 1011 mulhu (high WIDTH bits, unsigned)
  - 1100 divu
  - 1101 remu
  - 1110, 1111: illegal
- Shift amount is b[log2(WIDTH)-1:0]; upper bits of b are ignored.
- Sub is computed as a + ~b + 1.
- Overflow for add/sub: operand signs (b inverted for sub) agree and sum sign differs.
- slt is the sign of the sum XOR overflow. sltu is the inverted carry-out. Both zero-extend to WIDTH.
- Multiply: unsigned radix-2 shift-add over a 2·WIDTH product register, one bit per cycle.
- Divide: unsigned restoring, one quotient bit per cycle.
- Divide by zero: divu → all ones; remu → a. No extra cycles taken; the normal iteration count still applies.
- State machine:
  - IDLE → DONE on accept of a single-cycle or illegal op.
  - IDLE → BUSY on accept of an iterative op; the counter is loaded with WIDTH.
  - BUSY decrements the counter each cycle; at 1 → DONE.
  - DONE with out_ready → IDLE, or re-accepts directly (see Timing).
- Operands and op are captured on accept; input changes while BUSY are ignored.

## Timing
- Handshakes:
  - Accept: in_valid & in_ready.
  - Retire: out_valid & out_ready.
- in_ready = (state==IDLE) | (state==DONE & out_ready). A retire and a new accept in the same cycle are legal: one op per cycle for single-cycle ops.
- out_valid = (state==DONE).
- result, zero, overflow, illegal are stable while out_valid & ~out_ready.
- Latency from the accept cycle N:
  - Single-cycle/illegal: out_valid at N+1.
  - mul/mulhu/divu/remu: out_valid at N+1+WIDTH.
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, zero 1, overflow 0, illegal 0, counter 0.
- Reset mid-BUSY or mid-DONE: result discarded, IDLE next cycle, no out_valid.

## Configuration
- ALU_DIV_EN defined: divider datapath built; 1100/1101 behave as above.
- ALU_DIV_EN undefined: no divider logic. 1100/1101 are treated as illegal: single-cycle, result 0, illegal=1. Multiply is unaffected.

## Structure
- Package alu_pkg holds:
  - the op-code enum (4-bit)
  - the state enum IDLE/BUSY/DONE
  - a helper constant for shift-amount width as a function of WIDTH
- Sub-module alu_iter (WIDTH) owns the product/remainder register, quotient/multiplier shift register, and iteration counter. It has start, is_div, a, b, done, lo, hi. The top holds the FSM, single-cycle datapath, and output registers.

## Test plan
- add 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow 1, zero 0, out_valid exactly 1 cycle after accept. Then sub 5 − 5 → 0, zero 1.
- sra 0x80000000 by b=0x24 (amount 4) → 0xF8000000. srl same → 0x08000000. slt 1 vs 0xFFFFFFFF → 0. sltu → 1.
- mul 0xFFFFFFFF × 2 → 0xFFFFFFFE; mulhu → 0x00000001. out_valid at accept+33; in_ready 0 throughout BUSY.
- divu 100/7 → 14, remu → 2. divu 100/0 → 0xFFFFFFFF, remu → 100 (ALU_DIV_EN on). With ALU_DIV_EN off: divu → 0, illegal 1, latency 1.
- Back-pressure: out_ready low 5 cycles after an add result → result/flags unchanged, in_ready 0. Then out_ready high with in_valid high → retire and accept the next op in the same cycle, next result the following cycle.
- reset asserted at iteration 10 of mul → next cycle out_valid 0, in_ready 1. A fresh and 0xF0F0F0F0 & 0xFF00FF00 → 0xF000F000 one cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the alu_mdu execute unit:
//   - op_e      : 4-bit operation code
//   - state_e   : control FSM states (IDLE / BUSY / DONE)
//   - shamt_w() : shift-amount width as a function of the datapath width
// Optional feature macro used by the files importing this package: ALU_DIV_EN
// (builds the divider; otherwise divu/remu decode as illegal).
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_SLT   = 4'b0101,
        OP_SLTU  = 4'b0110,
        OP_SLL   = 4'b0111,
        OP_SRL   = 4'b1000,
        OP_SRA   = 4'b1001,
        OP_MUL   = 4'b1010,
        OP_MULHU = 4'b1011,
        OP_DIVU  = 4'b1100,
        OP_REMU  = 4'b1101,
        OP_RSV0  = 4'b1110,
        OP_RSV1  = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of b bits that form the shift amount for a given datapath width.
    function automatic int unsigned shamt_w(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// -----------------------------------------------------------------------------
// alu_iter
// Iterative engine for multiply (radix-2 shift/add) and, when ALU_DIV_EN is
// defined, unsigned restoring divide. One bit per cycle, WIDTH cycles per op.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears the counter)
//   start       : load operands and begin an operation
//   is_div      : 1 = divide, 0 = multiply (ignored without ALU_DIV_EN)
//   a, b        : operands (mul: a*b; div: a/b)
//   done        : high during the last iteration cycle
//   lo, hi      : next-state of the low/high registers; valid while done is high
//                 mul: lo = product[W-1:0], hi = product[2W-1:W]
//                 div: lo = quotient,       hi = remainder
// Macro: ALU_DIV_EN
// -----------------------------------------------------------------------------
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;    // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;    // multiplier / dividend-then-quotient
    logic [WIDTH-1:0] opd_q, opd_d;  // multiplicand / divisor
    logic [WIDTH:0]   add_sum;

`ifdef ALU_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
`else
    logic             unused_is_div;
    assign unused_is_div = is_div;
`endif

    always_comb begin
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opd_d   = opd_q;
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
`ifdef ALU_DIV_EN
        div_d    = div_q;
        rem_sh   = {hi_q, lo_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opd_q};
`endif
        if (start) begin
            cnt_d = CW'(WIDTH);
            hi_d  = '0;
`ifdef ALU_DIV_EN
            div_d = is_div;
            lo_d  = is_div ? a : b;
            opd_d = is_div ? b : a;
`else
            lo_d  = b;
            opd_d = a;
`endif
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
`ifdef ALU_DIV_EN
            if (div_q) begin
                // Restoring step: keep the subtraction only if it did not borrow.
                // A zero divisor never borrows, giving all-ones quotient and
                // remainder equal to the dividend without any special casing.
                if (!rem_diff[WIDTH]) begin
                    hi_d = rem_diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = rem_sh[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else
`endif
            begin
                // Shift-add: conditionally add multiplicand, shift {hi,lo} right.
                {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
        hi_q  <= hi_d;
        lo_q  <= lo_d;
        opd_q <= opd_d;
`ifdef ALU_DIV_EN
        div_q <= div_d;
`endif
    end

    // Results are exported as next-state so the top can register them on the
    // same edge that completes the final iteration.
    assign done = (cnt_q == CW'(1));
    assign lo   = lo_d;
    assign hi   = hi_d;

endmodule

// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu
// Handshaked execute unit: single-cycle ALU ops plus iterative multiply/divide.
// Single-cycle and illegal ops produce out_valid one cycle after accept;
// mul/mulhu/divu/remu produce out_valid WIDTH+1 cycles after accept.
//
// Parameters: WIDTH (>= 8, power of two)
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : request handshake (op, a, b captured on accept)
//   op                    : 4-bit operation code (alu_pkg::op_e)
//   a, b                  : operands
//   out_valid / out_ready : result handshake
//   result                : registered result
//   zero                  : result == 0
//   overflow              : signed overflow of add/sub, else 0
//   illegal               : unsupported op (result forced to 0)
// Macro: ALU_DIV_EN builds the divider; without it divu/remu are illegal.
// -----------------------------------------------------------------------------
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int SHW = int'(shamt_w(WIDTH));

    op_e              opc;
    state_e           state_q, state_d;
    logic             accept;

    // Single-cycle datapath
    logic             sub_mode;
    logic [WIDTH-1:0] b_add;
    logic [WIDTH:0]   sum;
    logic             add_ovf;
    logic             slt_bit;
    logic             sltu_bit;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;
    logic             sc_ill;
    logic             is_iter;
    logic             sel_hi;

    // Iterative engine
    logic             iter_start;
    logic             iter_is_div;
    logic             iter_done;
    logic [WIDTH-1:0] iter_lo, iter_hi, iter_res;

    // Output registers
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;
    logic             sel_hi_q, sel_hi_d;

    assign opc = op_e'(op);

    // slt/sltu reuse the subtractor: a + ~b + 1.
    assign sub_mode = (opc == OP_SUB) || (opc == OP_SLT) || (opc == OP_SLTU);
    assign b_add    = sub_mode ? ~b : b;
    assign sum      = {1'b0, a} + {1'b0, b_add} + {{WIDTH{1'b0}}, sub_mode};
    assign add_ovf  = (a[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign slt_bit  = sum[WIDTH-1] ^ add_ovf;
    assign sltu_bit = ~sum[WIDTH];
    assign shamt    = b[SHW-1:0];

    always_comb begin
        sc_res  = '0;
        sc_ovf  = 1'b0;
        sc_ill  = 1'b0;
        is_iter = 1'b0;
        sel_hi  = 1'b0;
        case (opc)
            OP_ADD, OP_SUB: begin
                sc_res = sum[WIDTH-1:0];
                sc_ovf = add_ovf;
            end
            OP_AND:   sc_res = a & b;
            OP_OR:    sc_res = a | b;
            OP_XOR:   sc_res = a ^ b;
            OP_SLT:   sc_res = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLTU:  sc_res = {{(WIDTH-1){1'b0}}, sltu_bit};
            OP_SLL:   sc_res = a << shamt;
            OP_SRL:   sc_res = a >> shamt;
            OP_SRA:   sc_res = $unsigned($signed(a) >>> shamt);
            OP_MUL:   is_iter = 1'b1;
            OP_MULHU: begin
                is_iter = 1'b1;
                sel_hi  = 1'b1;
            end
`ifdef ALU_DIV_EN
            OP_DIVU:  is_iter = 1'b1;
            OP_REMU: begin
                is_iter = 1'b1;
                sel_hi  = 1'b1;
            end
`endif
            default:  sc_ill = 1'b1;
        endcase
    end

    // Control FSM
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        // accept already implies IDLE, or DONE with a same-cycle retire
        if (accept) begin
            state_d = is_iter ? ST_BUSY : ST_DONE;
        end else if ((state_q == ST_BUSY) && iter_done) begin
            state_d = ST_DONE;
        end else if ((state_q == ST_DONE) && out_ready) begin
            state_d = ST_IDLE;
        end
    end

    assign iter_start = accept && is_iter;
`ifdef ALU_DIV_EN
    assign iter_is_div = (opc == OP_DIVU) || (opc == OP_REMU);
`else
    assign iter_is_div = 1'b0;
`endif

    alu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (iter_start),
        .is_div (iter_is_div),
        .a      (a),
        .b      (b),
        .done   (iter_done),
        .lo     (iter_lo),
        .hi     (iter_hi)
    );

    assign iter_res = sel_hi_q ? iter_hi : iter_lo;

    always_comb begin
        res_d    = res_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        sel_hi_d = sel_hi_q;
        if (accept) begin
            sel_hi_d = sel_hi;
        end
        if (accept && !is_iter) begin
            res_d  = sc_res;
            zero_d = (sc_res == '0);
            ovf_d  = sc_ovf;
            ill_d  = sc_ill;
        end else if ((state_q == ST_BUSY) && iter_done) begin
            res_d  = iter_res;
            zero_d = (iter_res == '0);
            ovf_d  = 1'b0;
            ill_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
        end
        sel_hi_q <= sel_hi_d;
    end

    assign result   = res_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_mdu.sv
// -----------------------------------------------------------------------------
// tb_alu_mdu
// Directed bench for alu_mdu (WIDTH = 32). Expected results are queued when a
// request is driven and checked when the unit retires a result. Honors
// ALU_DIV_EN for divu/remu expectations.
// -----------------------------------------------------------------------------
module tb_alu_mdu;

    localparam logic [3:0] ADD   = 4'h0;
    localparam logic [3:0] SUB   = 4'h1;
    localparam logic [3:0] AND_  = 4'h2;
    localparam logic [3:0] XOR_  = 4'h4;
    localparam logic [3:0] SLT   = 4'h5;
    localparam logic [3:0] SLTU  = 4'h6;
    localparam logic [3:0] SRL   = 4'h8;
    localparam logic [3:0] SRA   = 4'h9;
    localparam logic [3:0] MUL   = 4'hA;
    localparam logic [3:0] MULHU = 4'hB;
    localparam logic [3:0] DIVU  = 4'hC;
    localparam logic [3:0] REMU  = 4'hD;
    localparam logic [3:0] RSV   = 4'hE;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic        zero, overflow, illegal;
    logic [3:0]  op;
    logic [31:0] a, b, result;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int busy_rdy = 0;

    typedef struct {
        string       tag;
        logic [34:0] v;   // {illegal, overflow, zero, result}
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    alu_mdu #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] ex(input logic [31:0] r, input logic ovf, input logic ill);
        return {ill, ovf, (r == 32'd0), r};
    endfunction

    // Retire monitor: every completed handshake pops and checks one entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk(mon_e.tag, {29'd0, illegal, overflow, zero, result}, {29'd0, mon_e.v});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit push, input logic [34:0] e, input string tag);
        bit acc;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        if (push) sb.push_back('{tag, e});
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk({tag, "_accept_timeout"}, 0, 1);
        acc_cyc = cyc;
    endtask

    // Waits for out_valid, checks latency and in_ready low while waiting.
    task automatic wait_out(input string tag, input int exp_lat);
        bit got;
        got = 1'b0;
        busy_rdy = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
            else if (in_ready) busy_rdy++;
        end
        if (got) chk({tag, "_latency"}, cyc - acc_cyc, exp_lat);
        else chk({tag, "_out_timeout"}, 0, 1);
        chk({tag, "_in_ready_busy"}, busy_rdy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [34:0] e_divu, e_remu, e_divz, e_remz;
        int          lat_div;
        int          stale;

`ifdef ALU_DIV_EN
        e_divu  = ex(32'd14, 1'b0, 1'b0);
        e_remu  = ex(32'd2, 1'b0, 1'b0);
        e_divz  = ex(32'hFFFF_FFFF, 1'b0, 1'b0);
        e_remz  = ex(32'd100, 1'b0, 1'b0);
        lat_div = 32;
`else
        e_divu  = ex(32'd0, 1'b0, 1'b1);
        e_remu  = ex(32'd0, 1'b0, 1'b1);
        e_divz  = ex(32'd0, 1'b0, 1'b1);
        e_remz  = ex(32'd0, 1'b0, 1'b1);
        lat_div = 0;
`endif

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = 4'h0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_illegal", illegal, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        send(ADD, 32'h7FFF_FFFF, 32'h1, 1, ex(32'h8000_0000, 1'b1, 1'b0), "add_ovf");
        wait_out("add_ovf", 0);
        send(SUB, 32'd5, 32'd5, 1, ex(32'd0, 1'b0, 1'b0), "sub_zero");
        wait_out("sub_zero", 0);
        send(SRA, 32'h8000_0000, 32'h24, 1, ex(32'hF800_0000, 1'b0, 1'b0), "sra");
        wait_out("sra", 0);
        send(SRL, 32'h8000_0000, 32'h24, 1, ex(32'h0800_0000, 1'b0, 1'b0), "srl");
        wait_out("srl", 0);
        send(SLT, 32'd1, 32'hFFFF_FFFF, 1, ex(32'd0, 1'b0, 1'b0), "slt");
        wait_out("slt", 0);
        send(SLTU, 32'd1, 32'hFFFF_FFFF, 1, ex(32'd1, 1'b0, 1'b0), "sltu");
        wait_out("sltu", 0);
        send(SUB, 32'h8000_0000, 32'd1, 1, ex(32'h7FFF_FFFF, 1'b1, 1'b0), "sub_ovf");
        wait_out("sub_ovf", 0);
        send(RSV, 32'd9, 32'd9, 1, ex(32'd0, 1'b0, 1'b1), "illegal_op");
        wait_out("illegal_op", 0);

        send(MUL, 32'hFFFF_FFFF, 32'd2, 1, ex(32'hFFFF_FFFE, 1'b0, 1'b0), "mul");
        wait_out("mul", 32);
        send(MULHU, 32'hFFFF_FFFF, 32'd2, 1, ex(32'h0000_0001, 1'b0, 1'b0), "mulhu");
        wait_out("mulhu", 32);
        send(MUL, 32'd12345, 32'd6789, 1, ex(32'd83810205, 1'b0, 1'b0), "mul_mid");
        wait_out("mul_mid", 32);

        send(DIVU, 32'd100, 32'd7, 1, e_divu, "divu");
        wait_out("divu", lat_div);
        send(REMU, 32'd100, 32'd7, 1, e_remu, "remu");
        wait_out("remu", lat_div);
        send(DIVU, 32'd100, 32'd0, 1, e_divz, "divu_by0");
        wait_out("divu_by0", lat_div);
        send(REMU, 32'd100, 32'd0, 1, e_remz, "remu_by0");
        wait_out("remu_by0", lat_div);

        // Back-pressure: hold the add result, then retire and accept together.
        out_ready = 1'b0;
        send(ADD, 32'd3, 32'd4, 1, ex(32'd7, 1'b0, 1'b0), "bp_add");
        wait_out("bp_add", 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_result_hold", {29'd0, illegal, overflow, zero, result}, {29'd0, ex(32'd7, 1'b0, 1'b0)});
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(XOR_, 32'hF0, 32'h0F, 1, ex(32'hFF, 1'b0, 1'b0), "bp_next");
        wait_out("bp_next", 0);

        // Reset in the middle of a multiply: the result is never delivered.
        send(MUL, 32'd3, 32'd5, 0, '0, "rst_mul");
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, ex(32'hF000_F000, 1'b0, 1'b0), "and_after_rst");
        wait_out("and_after_rst", 0);

        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("no_stale_result", stale, 0);
        chk("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
